// File: rtl/final_sum_reducer.sv
// Reduces two float lane sums into a persistent single-precision running total.
// One multi-cycle float adder is reused for the lane pass and the accumulate pass.
module final_sum_reducer #(
    parameter int unsigned          FLT_DATA_WIDTH = 32,
    parameter int unsigned          N_WIDTH        = 2,
    parameter logic [N_WIDTH-1:0]   CLEAR          = N_WIDTH'(0),
    parameter logic [N_WIDTH-1:0]   GO             = N_WIDTH'(1),
    parameter logic [N_WIDTH-1:0]   READ           = N_WIDTH'(2)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_en,
    input  logic                      start,
    input  logic [N_WIDTH-1:0]        n,
    input  logic [FLT_DATA_WIDTH-1:0] sum_a,
    input  logic [FLT_DATA_WIDTH-1:0] sum_b,
    output logic                      busy,
    output logic                      done,
    output logic [FLT_DATA_WIDTH-1:0] result
);

    localparam int unsigned MAN_W = 27;
    localparam int unsigned EXP_W = 10;

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_PACK, S_DONE
    } state_t;

    state_t r_state, w_next;

    logic [31:0]             r_op_a, r_op_b, r_lane, r_total, r_result;
    logic                    r_pass;
    logic                    r_sa, r_sb, r_spec, r_spec_sign, r_negzero;
    logic [7:0]              r_ea, r_eb;
    logic [MAN_W-1:0]        r_ma, r_mb;
    logic                    r_sign, r_sub;
    logic signed [EXP_W-1:0] r_exp;
    logic [MAN_W-1:0]        r_am, r_bm;
    logic [MAN_W:0]          r_sum;

    function automatic logic [MAN_W-1:0] unpack_man(input logic [31:0] f);
        return (f[30:23] == 8'd0) ? MAN_W'(0) : {1'b1, f[22:0], 3'b000};
    endfunction

    function automatic logic [4:0] lzc27(input logic [MAN_W-1:0] v);
        logic [4:0] cnt;
        cnt = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) cnt = 5'(26 - i);
        end
        return cnt;
    endfunction

    // Pass 1 adds the captured lanes; pass 2 folds the lane total into the running total.
    logic [31:0] w_in_a, w_in_b;
    logic        w_inf_a, w_inf_b;
    assign w_in_a  = r_pass ? r_total : r_op_a;
    assign w_in_b  = r_pass ? r_lane  : r_op_b;
    assign w_inf_a = (w_in_a[30:23] == 8'hFF);
    assign w_inf_b = (w_in_b[30:23] == 8'hFF);

    logic             w_swap, w_big_s, w_sml_s;
    logic [7:0]       w_big_e, w_sml_e, w_diff;
    logic [MAN_W-1:0] w_big_m, w_sml_m, w_shifted;
    assign w_swap    = (r_eb > r_ea) || ((r_eb == r_ea) && (r_mb > r_ma));
    assign w_big_s   = w_swap ? r_sb : r_sa;
    assign w_sml_s   = w_swap ? r_sa : r_sb;
    assign w_big_e   = w_swap ? r_eb : r_ea;
    assign w_sml_e   = w_swap ? r_ea : r_eb;
    assign w_big_m   = w_swap ? r_mb : r_ma;
    assign w_sml_m   = w_swap ? r_ma : r_mb;
    assign w_diff    = w_big_e - w_sml_e;
    assign w_shifted = (w_diff >= 8'd27) ? MAN_W'(0) : (w_sml_m >> w_diff);

    logic [4:0]  w_lzc;
    logic [31:0] w_pack;
    assign w_lzc = lzc27(r_sum[MAN_W-1:0]);

    // Truncating pack with flush-to-zero and saturation to infinity.
    always_comb begin
        w_pack = {r_sign, r_exp[7:0], r_am[25:3]};
        if (r_spec)
            w_pack = {r_spec_sign, 8'hFF, 23'd0};
        else if (r_am == MAN_W'(0))
            w_pack = r_negzero ? 32'h8000_0000 : 32'h0000_0000;
        else if (r_exp <= 10'sd0)
            w_pack = {r_sign, 31'd0};
        else if (r_exp >= 10'sd255)
            w_pack = {r_sign, 8'hFF, 23'd0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else if (clk_en)
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = (n == GO) ? S_UNPACK : S_DONE;
            S_UNPACK: w_next = S_ALIGN;
            S_ALIGN:  w_next = S_ADD;
            S_ADD:    w_next = S_NORM;
            S_NORM:   w_next = S_PACK;
            S_PACK:   w_next = r_pass ? S_DONE : S_UNPACK;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE);
        done = (r_state == S_DONE);
    end

    assign result = r_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a <= '0; r_op_b <= '0; r_lane <= '0; r_total <= '0; r_result <= '0;
            r_pass <= 1'b0; r_sa <= 1'b0; r_sb <= 1'b0; r_ea <= '0; r_eb <= '0;
            r_ma <= '0; r_mb <= '0; r_spec <= 1'b0; r_spec_sign <= 1'b0; r_negzero <= 1'b0;
            r_sign <= 1'b0; r_sub <= 1'b0; r_exp <= '0; r_am <= '0; r_bm <= '0; r_sum <= '0;
        end else if (clk_en) begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_op_a <= sum_a;
                    r_op_b <= sum_b;
                    r_pass <= 1'b0;
                    if (n == CLEAR) begin
                        r_total  <= '0;
                        r_result <= '0;
                    end else if (n == READ) begin
                        r_result <= r_total;
                    end
                end
                S_UNPACK: begin
                    r_sa        <= w_in_a[31];
                    r_sb        <= w_in_b[31];
                    r_ea        <= w_in_a[30:23];
                    r_eb        <= w_in_b[30:23];
                    r_ma        <= unpack_man(w_in_a);
                    r_mb        <= unpack_man(w_in_b);
                    r_spec      <= w_inf_a | w_inf_b;
                    r_spec_sign <= (w_inf_a && w_inf_b) ? (w_in_a[31] & w_in_b[31])
                                 : (w_inf_a ? w_in_a[31] : w_in_b[31]);
                    r_negzero   <= (w_in_a[30:23] == 8'd0) && (w_in_b[30:23] == 8'd0)
                                 && w_in_a[31] && w_in_b[31];
                end
                S_ALIGN: begin
                    r_sign <= w_big_s;
                    r_sub  <= (w_big_s != w_sml_s);
                    r_exp  <= {2'b00, w_big_e};
                    r_am   <= w_big_m;
                    r_bm   <= w_shifted;
                end
                S_ADD: begin
                    r_sum <= r_sub ? ({1'b0, r_am} - {1'b0, r_bm})
                                   : ({1'b0, r_am} + {1'b0, r_bm});
                end
                S_NORM: begin
                    if (r_sum[MAN_W]) begin
                        r_am  <= r_sum[MAN_W:1];
                        r_exp <= r_exp + 10'sd1;
                    end else begin
                        r_am  <= r_sum[MAN_W-1:0] << w_lzc;
                        r_exp <= r_exp - $signed({5'd0, w_lzc});
                    end
                end
                S_PACK: begin
                    if (r_pass) begin
                        r_total  <= w_pack;
                        r_result <= w_pack;
                    end else begin
                        r_lane <= w_pack;
                        r_pass <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_final_sum_reducer.sv
// Directed bench for final_sum_reducer: command latency, float results and control corner cases.
module tb_final_sum_reducer;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        start;
    logic [1:0]  n;
    logic [31:0] sum_a, sum_b;
    logic        busy, done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_err = 0;

    final_sum_reducer dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .start(start), .n(n),
        .sum_a(sum_a), .sum_b(sum_b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one command, then check latency, busy span, result and return to idle.
    task automatic run_cmd(input string tag, input logic [1:0] cmd,
                           input logic [31:0] a, input logic [31:0] b,
                           input int lat, input logic [31:0] exp_res,
                           input int hold_at, input int hold_len, input bit poke);
        int k;
        int nb;
        start = 1'b1; n = cmd; sum_a = a; sum_b = b;
        tick();
        start = 1'b0;
        k = 1;
        nb = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && k < 60) begin
            if (k == hold_at) clk_en = 1'b0;
            if (k == hold_at + hold_len) clk_en = 1'b1;
            if (poke) begin
                start = (k % 3 == 1);
                n     = 2'd0;
            end
            tick();
            k++;
            if (busy === 1'b1) nb++;
        end
        start  = 1'b0;
        clk_en = 1'b1;
        chk({tag, " latency"}, 32'(k), 32'(lat));
        chk({tag, " busy_cycles"}, 32'(nb), 32'(lat));
        chk({tag, " result"}, result, exp_res);
        tick();
        chk({tag, " idle_after"}, {30'd0, busy, done}, 32'd0);
        chk({tag, " result_held"}, result, exp_res);
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1; start = 1'b0; n = 2'd0; sum_a = '0; sum_b = '0;
        tick(); tick();
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", result, 32'd0);
        rst = 1'b0;
        tick();

        run_cmd("read_after_reset", 2'd2, 32'h0, 32'h0, 1, 32'h0000_0000, -1, 0, 1'b0);
        run_cmd("go_1p0_2p0", 2'd1, 32'h3F80_0000, 32'h4000_0000, 11, 32'h4040_0000, -1, 0, 1'b0);
        run_cmd("go_half_half", 2'd1, 32'h3F00_0000, 32'h3F00_0000, 11, 32'h4080_0000, -1, 0, 1'b0);
        run_cmd("read_4p0", 2'd2, 32'h0, 32'h0, 1, 32'h4080_0000, -1, 0, 1'b0);
        run_cmd("go_cancel", 2'd1, 32'h3F80_0000, 32'hBF80_0000, 11, 32'h4080_0000, -1, 0, 1'b0);
        run_cmd("go_neg8", 2'd1, 32'hC100_0000, 32'h0000_0000, 11, 32'hC080_0000, -1, 0, 1'b0);
        run_cmd("noop_code3", 2'd3, 32'h1234_5678, 32'h9ABC_DEF0, 1, 32'hC080_0000, -1, 0, 1'b0);
        run_cmd("read_neg4", 2'd2, 32'h0, 32'h0, 1, 32'hC080_0000, -1, 0, 1'b0);

        run_cmd("clear_1", 2'd0, 32'h0, 32'h0, 1, 32'h0000_0000, -1, 0, 1'b0);
        run_cmd("go_denormal", 2'd1, 32'h0000_0001, 32'h3F80_0000, 11, 32'h3F80_0000, -1, 0, 1'b0);
        run_cmd("clear_2", 2'd0, 32'h0, 32'h0, 1, 32'h0000_0000, -1, 0, 1'b0);
        run_cmd("go_overflow", 2'd1, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 11, 32'h7F80_0000, -1, 0, 1'b0);
        run_cmd("clear_3", 2'd0, 32'h0, 32'h0, 1, 32'h0000_0000, -1, 0, 1'b0);
        run_cmd("go_align", 2'd1, 32'h4B80_0000, 32'h3F80_0000, 11, 32'h4B80_0000, -1, 0, 1'b0);

        // 2^24 + 2 is representable; stray CLEAR strobes while busy must be ignored.
        run_cmd("go_with_pokes", 2'd1, 32'h3F80_0000, 32'h3F80_0000, 11, 32'h4B80_0001, -1, 0, 1'b1);
        // 2^24+2 + 5 truncates to 2^24+6; five frozen cycles push done out by five.
        run_cmd("go_clk_en_hold", 2'd1, 32'h4000_0000, 32'h4040_0000, 16, 32'h4B80_0003, 3, 5, 1'b0);

        run_cmd("clear_4", 2'd0, 32'h0, 32'h0, 1, 32'h0000_0000, -1, 0, 1'b0);
        run_cmd("read_cleared", 2'd2, 32'h0, 32'h0, 1, 32'h0000_0000, -1, 0, 1'b0);

        // Build total=3.0, then reset in the middle of pass 2 of the next GO.
        run_cmd("go_total3", 2'd1, 32'h3F80_0000, 32'h4000_0000, 11, 32'h4040_0000, -1, 0, 1'b0);
        start = 1'b1; n = 2'd1; sum_a = 32'h3F80_0000; sum_b = 32'h3F80_0000;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("midop busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("midop busy", 32'(busy), 32'd0);
        chk("midop done", 32'(done), 32'd0);
        chk("midop result", result, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        run_cmd("read_after_midop_rst", 2'd2, 32'h0, 32'h0, 1, 32'h0000_0000, -1, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/final_sum_reducer.md
Name: final_sum_reducer

Overview:
- Downstream consumer of the function-evaluation block's two lane partial sums (sum_one, sum_two).
- On a GO command, adds the two lanes, then adds that lane total into a persistent running total, all as IEEE-754 single precision.
- Also serves the CLEAR and READ commands.
- Uses a fixed-latency multi-cycle adder FSM, one float adder reused for both passes.

Parameters:
- FLT_DATA_WIDTH, 32, float word width (IEEE single; fixed, not for resizing)
- N_WIDTH, 2, command field width
- CLEAR, 2'd0, command code: zero the running total
- GO, 2'd1, command code: reduce lanes into the total
- READ, 2'd2, command code: present the total

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- clk_en  input  1  global enable; when low all state, counters and outputs hold
- start  input  1  command strobe, sampled only in IDLE with clk_en high
- n  input  N_WIDTH  command code, sampled with start
- sum_a  input  32  lane-one partial sum, captured at command accept
- sum_b  input  32  lane-two partial sum, captured at command accept
- busy  output  1  high whenever state != IDLE
- done  output  1  one-enabled-cycle completion pulse
- result  output  32  GO: new total; READ: current total; CLEAR: 0

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; total=0; busy=0; done=0; result=0; operand regs=0.
  - Reset mid-operation aborts and clears everything; no partial update of total.
- Cycle C is the enabled cycle in which the command is accepted (start=1 in IDLE). All cycle counts below are enabled cycles.
- start while busy is ignored; no queueing. Command code 2'd3 is accepted but treated as a no-op: DONE at C+1, result unchanged.
- States: IDLE, UNPACK, ALIGN, ADD, NORM, PACK, DONE. A pass flag selects pass 1 or pass 2.
- GO:
  - Pass 1 computes lane = sum_a + sum_b and occupies C+1..C+5 (UNPACK, ALIGN, ADD, NORM, PACK).
  - Pass 2 computes total + lane and occupies C+6..C+10.
  - DONE at C+11: total and result take the pass-2 value, done=1.
  - Next enabled cycle: IDLE, done=0.
- CLEAR: DONE at C+1; total=0, result=0, done=1.
- READ: DONE at C+1; result=total, done=1; total unchanged.
- result holds its value between commands. done is exactly one enabled cycle wide; if clk_en drops during DONE, done is held.
- Adder arithmetic:
  - UNPACK:
    - Exponent field 0 (zero/denormal) is flushed to signed zero.
    - Otherwise the mantissa is {1, frac}, extended by 3 low guard bits.
  - ALIGN:
    - Swap so operand A has the larger magnitude (exponent, then mantissa).
    - Right-shift B by the exponent difference; a difference of 27 or more makes B zero.
  - ADD: equal signs add; otherwise A minus B. Result sign is A's sign.
  - NORM:
    - On carry-out, shift right 1 and increment the exponent.
    - Otherwise left-shift by the leading-zero count (combinational LZC) and decrement the exponent by that amount.
  - PACK:
    - Truncate the guard bits (round toward zero).
    - A zero mantissa gives +0 (exact cancellation is always +0).
    - Exponent <= 0 flushes to signed zero.
    - Exponent >= 255 saturates to signed infinity (exp=255, frac=0).
  - Input exponent 255 (Inf/NaN) yields signed infinity of that operand. If both are infinite with opposite signs, the result is +Inf. NaN is not propagated.
- Both operands zero: result +0, except -0 + -0 = -0.

Test Plan:
- After reset: READ -> done at C+1, result=0x00000000, busy low afterward.
- GO with sum_a=0x3F800000 (1.0), sum_b=0x40000000 (2.0) -> busy C+1..C+11, done at C+11, result=0x40400000. Then GO with 0x3F000000+0x3F000000 -> result=0x40800000 (4.0). Then READ -> 0x40800000.
- Cancellation and sign: from total=4.0, GO with 0x3F800000+0xBF800000 -> result=0x40800000. Then GO with 0xC1000000 (-8.0)+0x00000000 -> 0xC0800000 (-4.0).
- Edge operands:
  - Denormal: sum_a=0x00000001, sum_b=0x3F800000 from cleared total -> 0x3F800000.
  - Overflow: CLEAR, then GO 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000.
  - Alignment: 0x4B800000 (2^24) + 0x3F800000 -> 0x4B800000 (truncated).
- Control:
  - start pulses during a GO -> ignored, done exactly once.
  - clk_en low for 5 cycles mid-pass -> done delayed by exactly 5 cycles, same result.
  - CLEAR then READ -> 0x00000000.
- Reset mid-op: assert rst at C+7 of a GO from total=3.0 -> outputs zero immediately; after release, READ -> 0x00000000, busy=0.
